nibble_serial_add_ctrl: RTL



---
 rtl/nsa_pkg.sv | 14 +
 rtl/four_bit_add_dp.sv | 29 ++
 rtl/nibble_serial_add_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM state encoding
// and the width of the nibble index register.
package nsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width bounds the operand size to 2**NIB_W nibbles.
    localparam int NIB_W = 8;

endpackage

// File: rtl/four_bit_add_dp.sv
// Combinational 4-bit ripple adder datapath, reused every ADD step.
// With SIGNED_OVF_EN defined it also exports c3, the carry into bit 3.
module four_bit_add_dp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
`ifdef SIGNED_OVF_EN
    ,
    output logic       c3
`endif
);

    logic [4:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {4'b0000, c0};
    assign s      = w_full[3:0];
    assign c4     = w_full[4];

`ifdef SIGNED_OVF_EN
    // Carry into the MSB comes from the low three bits alone.
    logic [3:0] w_low;

    assign w_low = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, c0};
    assign c3    = w_low[3];
`endif

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single shared
// 4-bit adder. Optional two's-complement overflow output via SIGNED_OVF_EN.
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_badWidth
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
    if (NIB > (2 ** NIB_W)) begin : g_badIndex
        $error("nibble_serial_add_ctrl: WIDTH exceeds the nibble index range");
    end

    state_t             r_state;
    state_t             r_stateNext;
    logic [NIB_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic [3:0]         w_aNib;
    logic [3:0]         w_bNib;
    logic [3:0]         w_s;
    logic               w_c4;
    logic               w_lastStep;

    assign w_lastStep = (r_idx == NIB_W'(NIB - 1));

    // Select the active nibble of each captured operand.
    always_comb begin
        w_aNib = 4'h0;
        w_bNib = 4'h0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == NIB_W'(n)) begin
                w_aNib = r_a[4*n +: 4];
                w_bNib = r_b[4*n +: 4];
            end
        end
    end

`ifdef SIGNED_OVF_EN
    logic w_c3;
    logic r_ovf;

    four_bit_add_dp u_adder (
        .a  (w_aNib),
        .b  (w_bNib),
        .c0 (r_carry),
        .s  (w_s),
        .c4 (w_c4),
        .c3 (w_c3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_ADD && w_lastStep) begin
            r_ovf <= w_c3 ^ w_c4;
        end
    end

    assign ovf = r_ovf;
`else
    four_bit_add_dp u_adder (
        .a  (w_aNib),
        .b  (w_bNib),
        .c0 (r_carry),
        .s  (w_s),
        .c4 (w_c4)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= r_stateNext;
        end
    end

    always_comb begin
        r_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    r_stateNext = ST_ADD;
                end
            end
            ST_ADD: begin
                busy = 1'b1;
                if (w_lastStep) begin
                    r_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                r_stateNext = ST_IDLE;
            end
            default: begin
                r_stateNext = ST_IDLE;
            end
        endcase
    end

    // Operand capture on an accepted start, then one result nibble per ADD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                ST_ADD: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (r_idx == NIB_W'(n)) begin
                            r_sum[4*n +: 4] <= w_s;
                        end
                    end
                    r_carry <= w_c4;
                    if (w_lastStep) begin
                        r_cout <= w_c4;
                    end else begin
                        r_idx <= r_idx + NIB_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
